// File: rtl/alu_addsub_pipe_pkg.sv
// Shared opcode constants, flag bundle and default width for the pipelined ALU add/sub unit.
package alu_pkg;

    localparam int         ALU_WIDTH = 32;
    localparam logic [4:0] OP_ADD    = 5'd6;
    localparam logic [4:0] OP_SUB    = 5'd7;

    typedef struct packed {
        logic carry;
        logic overflow;
        logic zero;
        logic neg;
    } alu_flags_t;

    // Flag state presented while no result has been produced (result reads as 0).
    function automatic alu_flags_t flags_idle();
        alu_flags_t f;
        f.carry    = 1'b0;
        f.overflow = 1'b0;
        f.zero     = 1'b1;
        f.neg      = 1'b0;
        return f;
    endfunction

endpackage

// File: rtl/alu_addsub_pipe_if.sv
// Operand/result handshake bundle between the decode stage, the add/sub pipe and writeback.
interface alu_addsub_pipe_if
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] ALU_dat1;
    logic [WIDTH-1:0] ALU_dat2;
    logic [4:0]       decryptedOP;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] AddSub_out;
    logic             AddSub_carry;
    logic             AddSub_overflow;
    logic             AddSub_zero;
    logic             AddSub_neg;

    modport master (
        output in_valid, ALU_dat1, ALU_dat2, decryptedOP, out_ready,
        input  in_ready, out_valid, AddSub_out, AddSub_carry, AddSub_overflow,
               AddSub_zero, AddSub_neg
    );

    modport slave (
        input  in_valid, ALU_dat1, ALU_dat2, decryptedOP, out_ready,
        output in_ready, out_valid, AddSub_out, AddSub_carry, AddSub_overflow,
               AddSub_zero, AddSub_neg
    );

endinterface

// File: rtl/alu_addsub_pipe_slice.sv
// One S-bit slice of the segmented carry chain: plain adder with carry in and carry out.
module addsub_slice
    import alu_pkg::*;
#(
    parameter int S = 16
) (
    input  logic [S-1:0] a,
    input  logic [S-1:0] b,
    input  logic         cin,
    output logic [S-1:0] sum,
    output logic         cout
);
    logic [S:0] full_s;

    assign full_s = {1'b0, a} + {1'b0, b} + {{S{1'b0}}, cin};
    assign sum    = full_s[S-1:0];
    assign cout   = full_s[S];

endmodule

// File: rtl/alu_addsub_pipe.sv
// Pipelined WIDTH-bit ADD/SUB with a segmented carry chain over STAGES registered slices.
// Define ALU_ADDSUB_SAT_EN to saturate the result on signed overflow instead of wrapping.
module alu_addsub_pipe
    import alu_pkg::*;
#(
    parameter int         WIDTH  = ALU_WIDTH,
    parameter int         STAGES = 2,
    parameter logic [4:0] OP_ADD = alu_pkg::OP_ADD,
    parameter logic [4:0] OP_SUB = alu_pkg::OP_SUB
) (
    input  logic             soc_clk,
    input  logic             reset,
    alu_addsub_pipe_if.slave bus
);
    localparam int S    = WIDTH / STAGES;
    localparam int LAST = STAGES - 1;

    logic             advance_s;
    logic [WIDTH-1:0] a_in_s;
    logic [WIDTH-1:0] b_in_s;
    logic             cin_s;

    // Per-stage operands seen by slice k: index 0 is the live input, k>0 the stage k-1 register.
    logic [WIDTH-1:0] a_s     [STAGES];
    logic [WIDTH-1:0] b_s     [STAGES];
    logic [WIDTH-1:0] r_s     [STAGES];
    logic             c_s     [STAGES];
    logic             v_s     [STAGES];
    logic [S-1:0]     sum_s   [STAGES];
    logic             cout_s  [STAGES];
    logic [WIDTH-1:0] r_nxt_s [STAGES];

    logic [WIDTH-1:0] a_r [STAGES];
    logic [WIDTH-1:0] b_r [STAGES];
    logic [WIDTH-1:0] r_r [STAGES];
    logic             c_r [STAGES];
    logic             v_r [STAGES];

    logic             ovf_s;
    logic [WIDTH-1:0] res_s;
    alu_flags_t       flags_s;
    logic [WIDTH-1:0] out_r;
    alu_flags_t       flags_r;

    assign advance_s = ~v_r[LAST] | bus.out_ready;

    // Operand decode: SUB inverts B and injects carry 1; unknown opcodes flow through as 0 + 0.
    always_comb begin
        a_in_s = {WIDTH{1'b0}};
        b_in_s = {WIDTH{1'b0}};
        cin_s  = 1'b0;
        if (bus.decryptedOP == OP_ADD) begin
            a_in_s = bus.ALU_dat1;
            b_in_s = bus.ALU_dat2;
            cin_s  = 1'b0;
        end else if (bus.decryptedOP == OP_SUB) begin
            a_in_s = bus.ALU_dat1;
            b_in_s = ~bus.ALU_dat2;
            cin_s  = 1'b1;
        end else begin
            a_in_s = {WIDTH{1'b0}};
            b_in_s = {WIDTH{1'b0}};
            cin_s  = 1'b0;
        end
    end

    // Stage input selection: first stage from the bus, later stages from the previous register.
    always_comb begin
        a_s[0] = a_in_s;
        b_s[0] = b_in_s;
        r_s[0] = {WIDTH{1'b0}};
        c_s[0] = cin_s;
        v_s[0] = bus.in_valid;
        for (int k = 1; k < STAGES; k++) begin
            a_s[k] = a_r[k-1];
            b_s[k] = b_r[k-1];
            r_s[k] = r_r[k-1];
            c_s[k] = c_r[k-1];
            v_s[k] = v_r[k-1];
        end
    end

    for (genvar g = 0; g < STAGES; g++) begin : g_slice
        addsub_slice #(.S(S)) u_slice (
            .a    (a_s[g][g*S +: S]),
            .b    (b_s[g][g*S +: S]),
            .cin  (c_s[g]),
            .sum  (sum_s[g]),
            .cout (cout_s[g])
        );
    end

    // Merge each stage's new slice into the result bits carried from earlier stages.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            r_nxt_s[k]            = r_s[k];
            r_nxt_s[k][k*S +: S]  = sum_s[k];
        end
    end

    // Final-stage result and flags; the top A/B' slice is the one that lands in the last stage.
    always_comb begin
        ovf_s = (a_s[LAST][WIDTH-1] == b_s[LAST][WIDTH-1]) &&
                (r_nxt_s[LAST][WIDTH-1] != a_s[LAST][WIDTH-1]);
`ifdef ALU_ADDSUB_SAT_EN
        if (ovf_s) begin
            res_s = a_s[LAST][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                       : {1'b0, {(WIDTH-1){1'b1}}};
        end else begin
            res_s = r_nxt_s[LAST];
        end
`else
        res_s = r_nxt_s[LAST];
`endif
        flags_s.carry    = cout_s[LAST];
        flags_s.overflow = ovf_s;
        flags_s.zero     = ~|res_s;
        flags_s.neg      = res_s[WIDTH-1];
    end

    // Pipeline and output registers; a global stall freezes every stage together.
    always_ff @(posedge soc_clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < STAGES; k++) begin
                a_r[k] <= {WIDTH{1'b0}};
                b_r[k] <= {WIDTH{1'b0}};
                r_r[k] <= {WIDTH{1'b0}};
                c_r[k] <= 1'b0;
                v_r[k] <= 1'b0;
            end
            out_r   <= {WIDTH{1'b0}};
            flags_r <= flags_idle();
        end else if (advance_s) begin
            for (int k = 0; k < STAGES; k++) begin
                a_r[k] <= a_s[k];
                b_r[k] <= b_s[k];
                r_r[k] <= r_nxt_s[k];
                c_r[k] <= cout_s[k];
                v_r[k] <= v_s[k];
            end
            out_r   <= res_s;
            flags_r <= flags_s;
        end
    end

    assign bus.in_ready        = advance_s;
    assign bus.out_valid       = v_r[LAST];
    assign bus.AddSub_out      = out_r;
    assign bus.AddSub_carry    = flags_r.carry;
    assign bus.AddSub_overflow = flags_r.overflow;
    assign bus.AddSub_zero     = flags_r.zero;
    assign bus.AddSub_neg      = flags_r.neg;

endmodule

// File: tb/tb_alu_addsub_pipe.sv
// Scoreboard bench for alu_addsub_pipe: directed corner beats, back-pressure, reset flush, random traffic.
module tb_alu_addsub_pipe;
    import alu_pkg::*;

    localparam int STAGES = 2;

    typedef struct packed {
        logic [31:0] res;
        logic        carry;
        logic        ovf;
        logic        zero;
        logic        neg;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    alu_addsub_pipe_if #(.WIDTH(32)) bus ();

    alu_addsub_pipe #(.WIDTH(32), .STAGES(STAGES)) dut (
        .soc_clk (clk),
        .reset   (rst_n),
        .bus     (bus)
    );

    initial forever #5 clk = ~clk;

    // Reference: plain integer arithmetic on the architectural meaning of ADD/SUB.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic [4:0] op);
        exp_t                e;
        longint              sa, sb, s;
        longint unsigned     ua, ub, u;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'h0, a};
        ub = {32'h0, b};
        if (op == OP_ADD) begin
            s = sa + sb;
            u = ua + ub;
            e.res   = u[31:0];
            e.carry = u[32];
        end else if (op == OP_SUB) begin
            s = sa - sb;
            e.res   = a - b;
            e.carry = (a >= b);
        end else begin
            s = 64'sd0;
            e.res   = 32'h0;
            e.carry = 1'b0;
        end
        e.ovf = (s > 64'sh7FFFFFFF) || (s < -64'sh80000000);
`ifdef ALU_ADDSUB_SAT_EN
        if (e.ovf) e.res = (s > 64'sd0) ? 32'h7FFFFFFF : 32'h80000000;
`endif
        e.zero = (e.res == 32'h0);
        e.neg  = e.res[31];
        return e;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got=%h want=%h", name, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [4:0] op);
        int   n;
        logic ok;
        n  = 0;
        ok = 1'b0;
        bus.in_valid    = 1'b1;
        bus.ALU_dat1    = a;
        bus.ALU_dat2    = b;
        bus.decryptedOP = op;
        while (!ok && n < 100) begin
            @(negedge clk);
            ok = bus.in_ready;
            step();
            n++;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got=not_accepted want=accepted");
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        bus.out_ready = 1'b1;
        while (exp_q.size() != 0 && n < 50) begin
            step();
            n++;
        end
        check("drain_pending", 64'(exp_q.size()), 64'd0);
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h00000000;
            1:       return 32'h00000001;
            2:       return 32'hFFFFFFFF;
            3:       return 32'h7FFFFFFF;
            4:       return 32'h80000000;
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [4:0] rand_op();
        logic [4:0] op;
        case ($urandom_range(0, 9))
            0, 1, 2, 3: op = OP_ADD;
            4, 5, 6, 7: op = OP_SUB;
            default: begin
                op = 5'($urandom_range(0, 31));
                if (op == OP_ADD || op == OP_SUB) op = 5'd3;
            end
        endcase
        return op;
    endfunction

    // Scoreboard push: every beat the DUT will accept at the next rising edge.
    initial forever begin
        @(negedge clk);
        if (rst_n === 1'b1 && bus.in_valid && bus.in_ready)
            exp_q.push_back(model(bus.ALU_dat1, bus.ALU_dat2, bus.decryptedOP));
    end

    // Monitor: compare completed beats, hold stability and the ready rule.
    initial begin : monitor
        exp_t got, want, held;
        bit   hold;
        hold = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                hold = 1'b0;
            end else begin
                got = {bus.AddSub_out, bus.AddSub_carry, bus.AddSub_overflow,
                       bus.AddSub_zero, bus.AddSub_neg};
                check("in_ready_rule", 64'(bus.in_ready), 64'(!bus.out_valid || bus.out_ready));
                if (hold) begin
                    check("stall_valid", 64'(bus.out_valid), 64'd1);
                    check("stall_stable", 64'(got), 64'(held));
                end
                if (bus.out_valid && bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_result: got=%h want=none", got);
                    end else begin
                        want = exp_q.pop_front();
                        check("result", 64'(got), 64'(want));
                    end
                end
                hold = bus.out_valid && !bus.out_ready;
                held = got;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1);
    end

    initial begin : stim
        int cnt;
        rst_n           = 1'b0;
        bus.in_valid    = 1'b0;
        bus.ALU_dat1    = 32'h0;
        bus.ALU_dat2    = 32'h0;
        bus.decryptedOP = 5'd0;
        bus.out_ready   = 1'b1;
        repeat (3) step();

        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out", 64'(bus.AddSub_out), 64'd0);
        check("rst_flags", 64'({bus.AddSub_carry, bus.AddSub_overflow, bus.AddSub_zero, bus.AddSub_neg}),
              64'(4'b0010));
        rst_n = 1'b1;
        step();
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);

        // Latency of a lone ADD with no stall.
        send(32'd5, 32'd3, OP_ADD);
        cnt = 0;
        while (!bus.out_valid && cnt < 20) begin
            step();
            cnt++;
        end
        check("latency", 64'(cnt), 64'(STAGES - 1));
        wait_drain();

        // Directed corners.
        send(32'd5,        32'd3, OP_SUB);
        send(32'd3,        32'd5, OP_SUB);
        send(32'hFFFFFFFF, 32'd1, OP_ADD);
        send(32'h7FFFFFFF, 32'd1, OP_ADD);
        send(32'h80000000, 32'd1, OP_SUB);
        send(32'h12345678, 32'h9ABCDEF0, 5'd3);
        send(32'h80000000, 32'h80000000, OP_ADD);
        wait_drain();

        // Back-pressure: four ADDs, consumer stalls after the first result.
        bus.out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 4; i++) send($urandom, $urandom, OP_ADD);
            end
            begin
                int n;
                n = 0;
                while (!bus.out_valid && n < 20) begin
                    step();
                    n++;
                end
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    check("bp_in_ready", 64'(bus.in_ready), 64'd0);
                    step();
                end
                bus.out_ready = 1'b1;
                for (int i = 0; i < 4; i++) begin
                    @(negedge clk);
                    check("bp_stream", 64'(bus.out_valid), 64'd1);
                    step();
                end
            end
        join
        wait_drain();

        // Reset with two beats in flight: both must vanish.
        send(32'd100, 32'd1, OP_ADD);
        send(32'd200, 32'd2, OP_SUB);
        check("flight_valid", 64'(bus.out_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        check("rst_flush_valid", 64'(bus.out_valid), 64'd0);
        exp_q.delete();
        repeat (2) step();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("no_ghost", 64'(bus.out_valid), 64'd0);
            step();
        end

        // Randomized traffic with random back-pressure.
        for (int i = 0; i < 400; i++) begin
            bus.in_valid    = ($urandom_range(0, 3) != 0);
            bus.ALU_dat1    = rand_operand();
            bus.ALU_dat2    = rand_operand();
            bus.decryptedOP = rand_op();
            bus.out_ready   = ($urandom_range(0, 3) != 0);
            step();
        end
        bus.in_valid = 1'b0;
        wait_drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
